// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage and the hazard unit:
// datapath constants, the squash-state encoding and branch resolution.
package mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int RD_W   = 2;

  // States of the wrong-path squash machine (MEM_BRANCH_FLUSH_EN builds).
  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } squash_state_e;

  // An unconditional jump always takes. A conditional jump takes on zero
  // when neq is clear (jump-if-equal) and on nonzero when neq is set.
  function automatic logic branch_taken(input logic j, input logic jc,
                                        input logic neq, input logic zero);
    return j | (jc & (zero ^ neq));
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM with read-before-write behaviour.
// The storage lives here only, so a vendor macro can replace this file.
// Contents are deliberately not reset.
module data_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write on enable; the read captures the pre-write content of the same word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 16-bit accumulator pipeline: data-memory access, branch
// resolution and the MEM/WB register.
// Optional feature macro: MEM_BRANCH_FLUSH_EN adds the wrong-path squash
// machine, the flush output and a debug view of the squash state.
module mem_stage #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     WRMem,
  input  logic                     WMMem,
  input  logic                     RMMem,
  input  logic                     NEQMem,
  input  logic                     JMem,
  input  logic                     JCMem,
  input  logic                     zeroIn,
  input  logic [DATA_W-1:0]        acOutValue,
  input  logic [DATA_W-1:0]        rs,
  input  logic [DATA_W-1:0]        ulaJumpOut,
  input  logic [mem_pkg::RD_W-1:0] rdIn,
  output logic [DATA_W-1:0]        wbData,
  output logic [mem_pkg::RD_W-1:0] wbRd,
  output logic                     wbWR,
  output logic [DATA_W-1:0]        dataMem,
  output logic                     pcSrc,
  output logic [DATA_W-1:0]        pcTarget
`ifdef MEM_BRANCH_FLUSH_EN
  ,
  output logic                     flush,
  output logic                     dbg_state_o
`endif
);

  import mem_pkg::*;

  logic                squash;
  logic                wm_eff, wr_eff, j_eff, jc_eff, taken;
  logic [DATA_W-1:0]   ram_rdata;

  logic [DATA_W-1:0]   ac_q;
  logic                load_q;
  logic [RD_W-1:0]     rd_q;
  logic                wr_q;
  logic                pc_src_q;
  logic [DATA_W-1:0]   pc_target_q;

  // Upper address bits are intentionally ignored: addresses wrap.
  logic unused_rs_hi;
  assign unused_rs_hi = ^rs[DATA_W-1:ADDR_W];

`ifdef MEM_BRANCH_FLUSH_EN
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  squash_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Squash state and window counter; reset also cancels an open window.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Open the window on a taken branch; count it down and ignore branches inside.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (taken) begin
          state_d = SQUASH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end
      end
      SQUASH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign squash      = (state_q == SQUASH);
  assign flush       = squash;
  assign dbg_state_o = state_q;
`else
  // Without the squash machine every instruction commits; the delay slots
  // after a branch are the compiler's responsibility.
  localparam int unused_flush_cycles = FLUSH_CYCLES;
  assign squash = 1'b0;
`endif

  // Squashed instructions become bubbles: no store, no register write, no branch.
  assign wm_eff = WMMem & ~squash;
  assign wr_eff = WRMem & ~squash;
  assign j_eff  = JMem  & ~squash;
  assign jc_eff = JCMem & ~squash;
  assign taken  = branch_taken(j_eff, jc_eff, NEQMem, zeroIn);

  data_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_data_ram (
    .clk_i   (clock),
    .we_i    (wm_eff),
    .addr_i  (rs[ADDR_W-1:0]),
    .wdata_i (acOutValue),
    .rdata_o (ram_rdata)
  );

  // MEM/WB pipeline register and the one-cycle PC redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      ac_q        <= '0;
      load_q      <= 1'b0;
      rd_q        <= '0;
      wr_q        <= 1'b0;
      pc_src_q    <= 1'b0;
      pc_target_q <= '0;
    end else begin
      ac_q     <= acOutValue;
      load_q   <= RMMem;
      rd_q     <= rdIn;
      wr_q     <= wr_eff;
      pc_src_q <= taken;
      if (taken) begin
        pc_target_q <= ulaJumpOut;
      end
    end
  end

  assign wbData   = load_q ? ram_rdata : ac_q;
  assign dataMem  = wbData;
  assign wbRd     = rd_q;
  assign wbWR     = wr_q;
  assign pcSrc    = pc_src_q;
  assign pcTarget = pc_target_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage. Optional macro MEM_BRANCH_FLUSH_EN selects the
// squash scenarios; otherwise the delay-slot (always-commit) behaviour is run.
module tb_mem_stage;

  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          WRMem, WMMem, RMMem, NEQMem, JMem, JCMem, zeroIn;
  logic [DW-1:0] acOutValue, rs, ulaJumpOut;
  logic [1:0]    rdIn;
  logic [DW-1:0] wbData, dataMem, pcTarget;
  logic [1:0]    wbRd;
  logic          wbWR, pcSrc;
  logic          flush_w;
`ifdef MEM_BRANCH_FLUSH_EN
  logic          dbg_state;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage #(.DATA_W(16), .ADDR_W(8), .FLUSH_CYCLES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .WRMem      (WRMem),
    .WMMem      (WMMem),
    .RMMem      (RMMem),
    .NEQMem     (NEQMem),
    .JMem       (JMem),
    .JCMem      (JCMem),
    .zeroIn     (zeroIn),
    .acOutValue (acOutValue),
    .rs         (rs),
    .ulaJumpOut (ulaJumpOut),
    .rdIn       (rdIn),
    .wbData     (wbData),
    .wbRd       (wbRd),
    .wbWR       (wbWR),
    .dataMem    (dataMem),
    .pcSrc      (pcSrc),
    .pcTarget   (pcTarget)
`ifdef MEM_BRANCH_FLUSH_EN
    ,
    .flush      (flush_w),
    .dbg_state_o(dbg_state)
`endif
  );

`ifndef MEM_BRANCH_FLUSH_EN
  assign flush_w = 1'b0;
`endif

  // Clock
  always #5 clock = ~clock;

  // One rising edge, then settle before sampling outputs.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic wr, input logic wm, input logic rm,
                       input logic neq, input logic j, input logic jc,
                       input logic zero, input logic [DW-1:0] ac,
                       input logic [DW-1:0] addr, input logic [DW-1:0] tgt,
                       input logic [1:0] rd);
    WRMem = wr; WMMem = wm; RMMem = rm; NEQMem = neq; JMem = j; JCMem = jc;
    zeroIn = zero; acOutValue = ac; rs = addr; ulaJumpOut = tgt; rdIn = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'd0);
  endtask

  task automatic store(input logic [DW-1:0] addr, input logic [DW-1:0] val);
    drive(0, 1, 0, 0, 0, 0, 0, val, addr, 16'h0, 2'd0);
    cyc();
  endtask

  task automatic load_chk(input string tag, input logic [DW-1:0] addr,
                          input logic [DW-1:0] exp);
    drive(1, 0, 1, 0, 0, 0, 0, 16'h0, addr, 16'h0, 2'd1);
    cyc();
    chk(tag, 32'(wbData), 32'(exp));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wbData"},   32'(wbData),   32'h0);
    chk({tag, "_wbRd"},     32'(wbRd),     32'h0);
    chk({tag, "_wbWR"},     32'(wbWR),     32'h0);
    chk({tag, "_dataMem"},  32'(dataMem),  32'h0);
    chk({tag, "_pcSrc"},    32'(pcSrc),    32'h0);
    chk({tag, "_pcTarget"}, 32'(pcTarget), 32'h0);
    chk({tag, "_flush"},    32'(flush_w),  32'h0);
  endtask

  initial begin
    // Power-on reset
    reset = 1'b1;
    idle();
    cyc();
    cyc();
    chk_reset_outputs("por");
    reset = 1'b0;

    // Store then load through an aliased address (0x0112 wraps onto 0x12)
    drive(0, 1, 0, 0, 0, 0, 0, 16'hBEEF, 16'h0012, 16'h0, 2'd1);
    cyc();
    chk("store_wbData", 32'(wbData), 32'hBEEF);
    chk("store_wbWR",   32'(wbWR),   32'h0);
    drive(1, 0, 1, 0, 0, 0, 0, 16'h5555, 16'h0112, 16'h0, 2'd2);
    cyc();
    chk("wrap_load_wbData",  32'(wbData),  32'hBEEF);
    chk("wrap_load_dataMem", 32'(dataMem), 32'hBEEF);
    chk("wrap_load_wbRd",    32'(wbRd),    32'h2);
    chk("wrap_load_wbWR",    32'(wbWR),    32'h1);

    // Plain ALU result flows to write-back
    drive(1, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h0077, 16'h0, 2'd3);
    cyc();
    chk("alu_wbData", 32'(wbData), 32'h1234);
    chk("alu_wbRd",   32'(wbRd),   32'h3);

    // Same-edge store/load: old value returned, new value written
    store(16'h0005, 16'h1111);
    drive(1, 1, 1, 0, 0, 0, 0, 16'h2222, 16'h0005, 16'h0, 2'd1);
    cyc();
    chk("rbw_old", 32'(wbData), 32'h1111);
    load_chk("rbw_new", 16'h0005, 16'h2222);
    load_chk("rbw_new_hi", 16'hFF05, 16'h2222);

    // Jump-if-equal on zero: taken, one-cycle strobe
    drive(0, 0, 0, 0, 0, 1, 1, 16'h0, 16'h0, 16'h0040, 2'd0);
    cyc();
    chk("jeq_pcSrc",    32'(pcSrc),    32'h1);
    chk("jeq_pcTarget", 32'(pcTarget), 32'h0040);
    idle();
    cyc();
    chk("jeq_pcSrc_drop", 32'(pcSrc), 32'h0);
    cyc();

    // Jump-if-not-equal on zero: not taken
    drive(0, 0, 0, 1, 0, 1, 1, 16'h0, 16'h0, 16'h0040, 2'd0);
    cyc();
    chk("jne_zero_pcSrc", 32'(pcSrc), 32'h0);

    // Jump-if-not-equal on nonzero: taken
    drive(0, 0, 0, 1, 0, 1, 0, 16'h0, 16'h0, 16'h00C0, 2'd0);
    cyc();
    chk("jne_nz_pcSrc",    32'(pcSrc),    32'h1);
    chk("jne_nz_pcTarget", 32'(pcTarget), 32'h00C0);
    idle();
    cyc();
    cyc();

    // Unconditional jump wins over a false conditional
    drive(0, 0, 0, 0, 1, 1, 0, 16'h0, 16'h0, 16'h0080, 2'd0);
    cyc();
    chk("jprio_pcSrc",    32'(pcSrc),    32'h1);
    chk("jprio_pcTarget", 32'(pcTarget), 32'h0080);
    idle();
    cyc();
    cyc();

    // Reset mid-traffic with a taken jump on the inputs
    drive(1, 0, 0, 0, 1, 0, 0, 16'h9999, 16'h0001, 16'h0050, 2'd1);
    reset = 1'b1;
    cyc();
    cyc();
    chk_reset_outputs("mid_rst");
    reset = 1'b0;
    idle();
    cyc();
    chk("post_rst_pcSrc", 32'(pcSrc),   32'h0);
    chk("post_rst_flush", 32'(flush_w), 32'h0);

`ifdef MEM_BRANCH_FLUSH_EN
    // Wrong-path squash window of two instructions
    store(16'h0030, 16'h0303);
    store(16'h0031, 16'h0313);
    store(16'h0032, 16'h0323);
    drive(0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0060, 2'd0);
    cyc();
    chk("sq_pcSrc",  32'(pcSrc),     32'h1);
    chk("sq_flush1", 32'(flush_w),   32'h1);
    chk("sq_state",  32'(dbg_state), 32'(mem_pkg::SQUASH));
    drive(1, 1, 0, 0, 0, 0, 0, 16'hAAAA, 16'h0030, 16'h0, 2'd2);
    cyc();
    chk("sq_flush2",  32'(flush_w), 32'h1);
    chk("sq_wbData",  32'(wbData),  32'hAAAA);
    chk("sq_wbWR",    32'(wbWR),    32'h0);
    chk("sq_pcSrc2",  32'(pcSrc),   32'h0);
    drive(1, 1, 0, 0, 1, 0, 0, 16'hBBBB, 16'h0031, 16'h0070, 2'd2);
    cyc();
    chk("sq_flush_end", 32'(flush_w), 32'h0);
    chk("sq_no_pcSrc",  32'(pcSrc),   32'h0);
    chk("sq_wbWR2",     32'(wbWR),    32'h0);
    drive(1, 1, 0, 0, 0, 0, 0, 16'hCCCC, 16'h0032, 16'h0, 2'd2);
    cyc();
    chk("sq_commit_wbWR", 32'(wbWR), 32'h1);
    load_chk("sq_mem30", 16'h0030, 16'h0303);
    load_chk("sq_mem31", 16'h0031, 16'h0313);
    load_chk("sq_mem32", 16'h0032, 16'hCCCC);

    // Reset inside the window cancels it
    store(16'h0040, 16'h0000);
    drive(0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0090, 2'd0);
    cyc();
    chk("rsq_flush_on", 32'(flush_w), 32'h1);
    idle();
    reset = 1'b1;
    cyc();
    chk("rsq_flush_off", 32'(flush_w), 32'h0);
    reset = 1'b0;
    store(16'h0040, 16'hDDDD);
    chk("rsq_flush_idle", 32'(flush_w), 32'h0);
    load_chk("rsq_mem40", 16'h0040, 16'hDDDD);
`else
    // Delay slots commit; back-to-back taken jumps strobe twice
    store(16'h0020, 16'h0101);
    drive(0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0060, 2'd0);
    cyc();
    chk("ds_pcSrc", 32'(pcSrc), 32'h1);
    drive(1, 1, 0, 0, 1, 0, 0, 16'h7777, 16'h0020, 16'h0070, 2'd2);
    cyc();
    chk("b2b_pcSrc",    32'(pcSrc),    32'h1);
    chk("b2b_pcTarget", 32'(pcTarget), 32'h0070);
    chk("ds_wbWR",      32'(wbWR),     32'h1);
    idle();
    cyc();
    chk("b2b_pcSrc_drop", 32'(pcSrc), 32'h0);
    load_chk("ds_mem20", 16'h0020, 16'h7777);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
